sync_fifo_ram: RTL and testbench

Synchronous single-clock FIFO whose storage is a registered-read RAM array: a producer writes words through a push port and a consumer reads them through a pop port. Pop data appears one cycle after the request, matching the registered-read timing of the team's RAM primitives. It buffers byte and word streams between papiGB subsystems, such as CPU-to-peripheral queues and DMA staging, where producer and consumer share one clock but run at different rates.

---
 rtl/sync_fifo_ram_if.sv | 28 ++
 rtl/sync_fifo_ram.sv | 92 +++++++++
 tb/tb_sync_fifo_ram.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ram_if.sv
// Push/pop bundle for sync_fifo_ram: producer-side requests in, registered read data and status out.
// The FIFO takes the slave modport; the block that drives requests takes master.
interface sync_fifo_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  iClear;
    logic                  iPush;
    logic [DATA_WIDTH-1:0] iData;
    logic                  iPop;
    logic [DATA_WIDTH-1:0] oData;
    logic                  oValid;
    logic                  oFull;
    logic                  oEmpty;
    logic [DEPTH_LOG2:0]   oCount;
    logic                  oOverflow;
    logic                  oUnderflow;

    modport master (
        output iClear, iPush, iData, iPop,
        input  oData, oValid, oFull, oEmpty, oCount, oOverflow, oUnderflow
    );

    modport slave (
        input  iClear, iPush, iData, iPop,
        output oData, oValid, oFull, oEmpty, oCount, oOverflow, oUnderflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over a registered-read RAM array; popped words appear one cycle after the request.
// Status is decoded from the count register alone, so no request input reaches oFull/oEmpty/oCount combinationally.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    sync_fifo_ram_if.slave   fifo
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  advance;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  overflow;
    logic                  underflow;

    function automatic logic [DEPTH_LOG2:0] next_count(
        input logic [DEPTH_LOG2:0] cur,
        input logic                inc,
        input logic                dec
    );
        case ({inc, dec})
            2'b10:   return cur + 1'b1;
            2'b01:   return cur - 1'b1;
            default: return cur;
        endcase
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = fifo.iPush & ~full;
    assign pop_ok  = fifo.iPop & ~empty;
    // Reset and clear both suppress any request seen on the same edge.
    assign advance = ~Reset & ~fifo.iClear;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (fifo.iClear) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
            count  <= next_count(count, push_ok, pop_ok);
            vld_p1 <= pop_ok;
            if (fifo.iPush && full)  overflow  <= 1'b1;
            if (fifo.iPop  && empty) underflow <= 1'b1;
        end
    end

    // Storage is never reset; stale words just become unreachable when the pointers return to 0.
    always_ff @(posedge Clock) begin
        if (advance && push_ok) mem[wp] <= fifo.iData;
    end

    // Read stage p1: registered RAM output, held while no pop is accepted; clear leaves it alone.
    always_ff @(posedge Clock) begin
        if (Reset)
            rd_data_p1 <= '0;
        else if (advance && pop_ok)
            rd_data_p1 <= mem[rp];
    end

    assign fifo.oData      = rd_data_p1;
    assign fifo.oValid     = vld_p1;
    assign fifo.oFull      = full;
    assign fifo.oEmpty     = empty;
    assign fifo.oCount     = count;
    assign fifo.oOverflow  = overflow;
    assign fifo.oUnderflow = underflow;
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Randomized and directed bench for sync_fifo_ram (DEPTH=4, 8-bit words) against a queue-based reference model.
module tb_sync_fifo_ram;
    localparam int DW = 8;
    localparam int DL = 2;
    localparam int DEPTH = 1 << DL;

    logic Clock;
    logic Reset;
    sync_fifo_ram_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    sync_fifo_ram #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .fifo  (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue plus the visible output registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;
    bit            m_vld, m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic push,
                        input logic [DW-1:0] d, input logic pop);
        bit is_full, is_empty, p_ok, r_ok;
        Reset      = rst;
        bus.iClear = clr;
        bus.iPush  = push;
        bus.iData  = d;
        bus.iPop   = pop;
        @(posedge Clock);
        if (rst) begin
            q.delete();
            m_data = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
        end else if (clr) begin
            q.delete();
            m_vld = 0; m_ovf = 0; m_udf = 0;
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            p_ok = push && !is_full;
            r_ok = pop && !is_empty;
            m_vld = r_ok;
            if (r_ok) m_data = q.pop_front();
            if (push && is_full) m_ovf = 1;
            if (pop && is_empty) m_udf = 1;
            if (p_ok) q.push_back(d);
        end
        #1;
        check("data",  32'(bus.oData),      32'(m_data));
        check("valid", 32'(bus.oValid),     32'(m_vld));
        check("count", 32'(bus.oCount),     32'(q.size()));
        check("full",  32'(bus.oFull),      32'(q.size() == DEPTH));
        check("empty", 32'(bus.oEmpty),     32'(q.size() == 0));
        check("ovf",   32'(bus.oOverflow),  32'(m_ovf));
        check("udf",   32'(bus.oUnderflow), 32'(m_udf));
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0);
    endtask

    initial begin
        logic [DW-1:0] fill_pat [4];
        Reset = 1'b1; bus.iClear = 0; bus.iPush = 0; bus.iData = '0; bus.iPop = 0;
        fill_pat[0] = 8'h11; fill_pat[1] = 8'h22; fill_pat[2] = 8'h33; fill_pat[3] = 8'h44;

        // Reset state
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        idle();
        check("rst_empty", 32'(bus.oEmpty), 1);
        check("rst_full",  32'(bus.oFull), 0);
        check("rst_data",  32'(bus.oData), 0);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) step(0, 0, 1, fill_pat[i], 0);
        check("fill_full",  32'(bus.oFull), 1);
        check("fill_count", 32'(bus.oCount), 4);
        step(0, 0, 1, 8'h55, 0);
        check("ovf_flag",  32'(bus.oOverflow), 1);
        check("ovf_count", 32'(bus.oCount), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, 1);
            check("drain_data",  32'(bus.oData), 32'(fill_pat[i]));
            check("drain_valid", 32'(bus.oValid), 1);
        end
        check("drain_empty", 32'(bus.oEmpty), 1);
        idle();
        check("drain_vld_low", 32'(bus.oValid), 0);

        // Empty with push and pop together
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 8'hA5, 1);
        check("udf_flag",  32'(bus.oUnderflow), 1);
        check("udf_valid", 32'(bus.oValid), 0);
        check("udf_count", 32'(bus.oCount), 1);
        step(0, 0, 0, '0, 1);
        check("udf_data", 32'(bus.oData), 32'h A5);

        // Concurrent push/pop at count 2 across pointer wrap, then full simultaneity
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h01, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'(i + 2), 1);
            check("wrap_data",  32'(bus.oData), 32'(i));
            check("wrap_count", 32'(bus.oCount), 2);
        end
        step(0, 0, 1, 8'h0C, 0);
        step(0, 0, 1, 8'h0D, 0);
        check("wfull_count", 32'(bus.oCount), 4);
        step(0, 0, 1, 8'hEE, 1);
        check("wfull_ovf",   32'(bus.oOverflow), 1);
        check("wfull_count3", 32'(bus.oCount), 3);
        check("wfull_data",  32'(bus.oData), 32'h0A);

        // Mid-stream clear keeps oData, reset zeroes it
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 8'h71, 0);
        step(0, 0, 1, 8'h72, 0);
        step(0, 0, 1, 8'h73, 0);
        step(0, 0, 1, 8'h74, 1);
        step(0, 1, 1, 8'h75, 1);
        check("clr_count", 32'(bus.oCount), 0);
        check("clr_empty", 32'(bus.oEmpty), 1);
        check("clr_valid", 32'(bus.oValid), 0);
        check("clr_data",  32'(bus.oData), 32'h71);
        step(0, 0, 1, 8'h81, 0);
        step(0, 0, 1, 8'h82, 0);
        step(0, 0, 1, 8'h83, 0);
        step(0, 0, 1, 8'h84, 1);
        step(1, 0, 1, 8'h85, 1);
        check("rst2_count", 32'(bus.oCount), 0);
        check("rst2_data",  32'(bus.oData), 0);

        // Randomized traffic with push-heavy and pop-heavy phases
        for (int i = 0; i < 800; i++) begin
            int r;
            bit heavy_push;
            logic p, o, c, rs;
            r  = int'($urandom_range(0, 199));
            rs = (r == 0);
            c  = (r == 1 || r == 2);
            heavy_push = ((i / 40) % 2) == 0;
            p  = ($urandom_range(0, 3) < (heavy_push ? 3 : 1));
            o  = ($urandom_range(0, 3) < (heavy_push ? 1 : 3));
            step(rs, c, p, 8'($urandom), o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
